risc_v_id_ex_stage: RTL and testbench

//  ID/EX pipeline register with main control decode and load-use hazard unit.

---
 rtl/risc_v_id_ex_stage_if.sv | 63 ++++++
 rtl/risc_v_id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_risc_v_id_ex_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc_v_id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_id_ex_stage_if
// Description : Bundle of signals between the ID stage, the ID/EX pipeline
//               register and the EX stage / IF hazard controls.
//               slave  modport : the ID/EX register itself
//               master modport : the surrounding pipeline (or a testbench)
//               ID side  : PC_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID,
//                          FUNCT3_ID, FUNCT7_ID, OPCODE_ID, RD/RS1/RS2_ID, PCSrc
//               EX side  : registered copies plus decoded control
//               IF side  : PC_write, IF_ID_write, IF_ID_flush
//               STALL_CNT/FLUSH_CNT exist only when STALL_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_v_id_ex_stage_if #(
  parameter int XLEN = 32
`ifdef STALL_COUNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [XLEN-1:0] PC_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID;
  logic [2:0]      FUNCT3_ID;
  logic [6:0]      FUNCT7_ID, OPCODE_ID;
  logic [4:0]      RD_ID, RS1_ID, RS2_ID;
  logic            PCSrc;

  logic [XLEN-1:0] PC_EX, REG_DATA1_EX, REG_DATA2_EX, IMM_EX;
  logic [2:0]      FUNCT3_EX;
  logic [6:0]      FUNCT7_EX;
  logic [4:0]      RD_EX, RS1_EX, RS2_EX;
  logic            RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX;
  logic [1:0]      ALUOp_EX;

  logic            PC_write, IF_ID_write, IF_ID_flush;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
`endif

  modport slave (
    input  PC_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID, FUNCT3_ID, FUNCT7_ID,
           OPCODE_ID, RD_ID, RS1_ID, RS2_ID, PCSrc,
    output PC_EX, REG_DATA1_EX, REG_DATA2_EX, IMM_EX, FUNCT3_EX, FUNCT7_EX,
           RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX,
           MemWrite_EX, ALUSrc_EX, Branch_EX, ALUOp_EX,
           PC_write, IF_ID_write, IF_ID_flush
`ifdef STALL_COUNT_EN
    , output STALL_CNT, FLUSH_CNT
`endif
  );

  modport master (
    output PC_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID, FUNCT3_ID, FUNCT7_ID,
           OPCODE_ID, RD_ID, RS1_ID, RS2_ID, PCSrc,
    input  PC_EX, REG_DATA1_EX, REG_DATA2_EX, IMM_EX, FUNCT3_EX, FUNCT7_EX,
           RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX,
           MemWrite_EX, ALUSrc_EX, Branch_EX, ALUOp_EX,
           PC_write, IF_ID_write, IF_ID_flush
`ifdef STALL_COUNT_EN
    , input STALL_CNT, FLUSH_CNT
`endif
  );
endinterface
`default_nettype wire

// File: rtl/risc_v_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_id_ex_stage
// Description : ID/EX pipeline register with main control decode and a
//               load-use hazard unit. Loads a new entry on every rising edge;
//               a load-use stall or a taken-branch flush loads a bubble
//               (controls and RD_EX zero) instead of the decoded entry.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low
//               bus   - risc_v_id_ex_stage_if.slave (ID inputs, EX outputs,
//                       PC_write / IF_ID_write / IF_ID_flush)
// Option      : STALL_COUNT_EN - adds saturating STALL_CNT / FLUSH_CNT
//               counters (width CNT_W, must match the interface).
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_id_ex_stage
`ifdef STALL_COUNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic                  clk,
  input  logic                  reset,
  risc_v_id_ex_stage_if.slave   bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch;
  logic [1:0] alu_op;
  logic       use_rs1, use_rs2;
  logic       hazard, bubble;

  // Main control decode; unknown opcodes decode as a NOP.
  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    case (bus.OPCODE_ID)
      OP_R: begin
        reg_write = 1'b1; alu_op = 2'b10;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_I: begin
        reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10;
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        reg_write = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; alu_src = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        mem_write = 1'b1; alu_src = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1; alu_op = 2'b01;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Load in EX whose result is needed by the instruction in ID. Fields that
  // an instruction does not actually read (e.g. rs2 of addi) never match.
  assign hazard = bus.MemRead_EX && (bus.RD_EX != 5'd0) &&
                  ((use_rs1 && (bus.RS1_ID == bus.RD_EX)) ||
                   (use_rs2 && (bus.RS2_ID == bus.RD_EX)));

  // A taken branch outranks the stall: the ID instruction is squashed anyway.
  assign bubble          = hazard || bus.PCSrc;
  assign bus.PC_write    = bus.PCSrc || !hazard;
  assign bus.IF_ID_write = bus.PCSrc || !hazard;
  assign bus.IF_ID_flush = bus.PCSrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.PC_EX        <= '0;
      bus.REG_DATA1_EX <= '0;
      bus.REG_DATA2_EX <= '0;
      bus.IMM_EX       <= '0;
      bus.FUNCT3_EX    <= '0;
      bus.FUNCT7_EX    <= '0;
      bus.RD_EX        <= '0;
      bus.RS1_EX       <= '0;
      bus.RS2_EX       <= '0;
      bus.RegWrite_EX  <= 1'b0;
      bus.MemtoReg_EX  <= 1'b0;
      bus.MemRead_EX   <= 1'b0;
      bus.MemWrite_EX  <= 1'b0;
      bus.ALUSrc_EX    <= 1'b0;
      bus.Branch_EX    <= 1'b0;
      bus.ALUOp_EX     <= 2'b00;
    end else begin
      // Data and field copies load unconditionally, bubble or not.
      bus.PC_EX        <= bus.PC_ID;
      bus.REG_DATA1_EX <= bus.REG_DATA1_ID;
      bus.REG_DATA2_EX <= bus.REG_DATA2_ID;
      bus.IMM_EX       <= bus.IMM_ID;
      bus.FUNCT3_EX    <= bus.FUNCT3_ID;
      bus.FUNCT7_EX    <= bus.FUNCT7_ID;
      bus.RS1_EX       <= bus.RS1_ID;
      bus.RS2_EX       <= bus.RS2_ID;
      bus.RD_EX        <= bubble ? 5'd0 : bus.RD_ID;
      bus.RegWrite_EX  <= !bubble && reg_write;
      bus.MemtoReg_EX  <= !bubble && mem_to_reg;
      bus.MemRead_EX   <= !bubble && mem_read;
      bus.MemWrite_EX  <= !bubble && mem_write;
      bus.ALUSrc_EX    <= !bubble && alu_src;
      bus.Branch_EX    <= !bubble && branch;
      bus.ALUOp_EX     <= bubble ? 2'b00 : alu_op;
    end
  end

`ifdef STALL_COUNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.STALL_CNT <= '0;
      bus.FLUSH_CNT <= '0;
    end else begin
      if (hazard && !bus.PCSrc && (bus.STALL_CNT != '1))
        bus.STALL_CNT <= bus.STALL_CNT + CNT_W'(1);
      if (bus.PCSrc && (bus.FLUSH_CNT != '1))
        bus.FLUSH_CNT <= bus.FLUSH_CNT + CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc_v_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_v_id_ex_stage
// Description : Self-checking bench for risc_v_id_ex_stage. Directed pipeline
//               scenarios followed by random instruction streams, all checked
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_v_id_ex_stage;
  localparam int XLEN = 32;
`ifdef STALL_COUNT_EN
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef STALL_COUNT_EN
  risc_v_id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  risc_v_id_ex_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  risc_v_id_ex_stage_if #(.XLEN(XLEN)) bus ();
  risc_v_id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the EX entry.
  logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [2:0]      m_f3;
  logic [6:0]      m_f7;
  logic [4:0]      m_rd, m_rs1, m_rs2;
  logic [7:0]      m_ctrl;  // {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,Branch,ALUOp}
  int              m_stall, m_flush;

  function automatic logic [7:0] ctrl_of(input logic [6:0] op);
    case (op)
      OP_R:      return 8'b1000_0010;
      OP_I:      return 8'b1000_1010;
      OP_LOAD:   return 8'b1110_1000;
      OP_STORE:  return 8'b0001_1000;
      OP_BRANCH: return 8'b0000_0101;
      default:   return 8'b0000_0000;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_f3 = '0; m_f7 = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_ctrl = '0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_ex();
    check_value("pc_ex",    bus.PC_EX,        m_pc);
    check_value("d1_ex",    bus.REG_DATA1_EX, m_d1);
    check_value("d2_ex",    bus.REG_DATA2_EX, m_d2);
    check_value("imm_ex",   bus.IMM_EX,       m_imm);
    check_value("f3_ex",    bus.FUNCT3_EX,    m_f3);
    check_value("f7_ex",    bus.FUNCT7_EX,    m_f7);
    check_value("rd_ex",    bus.RD_EX,        m_rd);
    check_value("rs1_ex",   bus.RS1_EX,       m_rs1);
    check_value("rs2_ex",   bus.RS2_EX,       m_rs2);
    check_value("ctrl_ex",  {bus.RegWrite_EX, bus.MemtoReg_EX, bus.MemRead_EX, bus.MemWrite_EX,
                             bus.ALUSrc_EX, bus.Branch_EX, bus.ALUOp_EX}, m_ctrl);
`ifdef STALL_COUNT_EN
    check_value("stall_cnt", bus.STALL_CNT, m_stall);
    check_value("flush_cnt", bus.FLUSH_CNT, m_flush);
`endif
  endtask

  // One pipeline cycle: present an ID instruction, check the hazard outputs,
  // advance the model, then check the EX entry after the edge.
  task automatic step(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic pcsrc,
                      output logic pw, output logic fl);
    bit haz, bub;
    @(negedge clk);
    bus.OPCODE_ID    = op;
    bus.RD_ID        = rd;
    bus.RS1_ID       = rs1;
    bus.RS2_ID       = rs2;
    bus.PCSrc        = pcsrc;
    bus.PC_ID        = $urandom;
    bus.REG_DATA1_ID = $urandom;
    bus.REG_DATA2_ID = $urandom;
    bus.IMM_ID       = $urandom;
    bus.FUNCT3_ID    = 3'($urandom_range(0, 7));
    bus.FUNCT7_ID    = 7'($urandom_range(0, 127));
    #1;
    haz = (m_ctrl[5] == 1'b1) && (m_rd != 5'd0) &&
          ((reads_rs1(op) && rs1 == m_rd) || (reads_rs2(op) && rs2 == m_rd));
    check_value("pc_write",    bus.PC_write,    (haz && !pcsrc) ? 0 : 1);
    check_value("if_id_write", bus.IF_ID_write, (haz && !pcsrc) ? 0 : 1);
    check_value("if_id_flush", bus.IF_ID_flush, pcsrc);
    pw = bus.PC_write;
    fl = bus.IF_ID_flush;
    bub    = haz || pcsrc;
    m_pc   = bus.PC_ID;
    m_d1   = bus.REG_DATA1_ID;
    m_d2   = bus.REG_DATA2_ID;
    m_imm  = bus.IMM_ID;
    m_f3   = bus.FUNCT3_ID;
    m_f7   = bus.FUNCT7_ID;
    m_rs1  = rs1;
    m_rs2  = rs2;
    m_rd   = bub ? 5'd0 : rd;
    m_ctrl = bub ? 8'd0 : ctrl_of(op);
`ifdef STALL_COUNT_EN
    if (haz && !pcsrc && m_stall < CNT_MAX) m_stall++;
    if (pcsrc && m_flush < CNT_MAX) m_flush++;
`endif
    @(posedge clk);
    #1;
    check_ex();
  endtask

  initial begin
    logic pw, fl;
    logic [6:0] op;
    logic [6:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;

    bus.OPCODE_ID = '0; bus.RD_ID = '0; bus.RS1_ID = '0; bus.RS2_ID = '0;
    bus.PCSrc = 1'b0; bus.PC_ID = '0; bus.REG_DATA1_ID = '0; bus.REG_DATA2_ID = '0;
    bus.IMM_ID = '0; bus.FUNCT3_ID = '0; bus.FUNCT7_ID = '0;
    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    check_ex();
    check_value("rst_pc_write", bus.PC_write, 1);
    check_value("rst_if_id_write", bus.IF_ID_write, 1);
    reset = 1'b1;

    // add x3,x1,x2
    step(OP_R, 5'd3, 5'd1, 5'd2, 1'b0, pw, fl);
    check_value("add_regwrite", bus.RegWrite_EX, 1);
    check_value("add_alusrc", bus.ALUSrc_EX, 0);
    check_value("add_aluop", bus.ALUOp_EX, 2'b10);
    check_value("add_rd", bus.RD_EX, 3);

    // lw x5 then dependent add x6,x5,x1: one bubble, then the add enters EX
    step(OP_LOAD, 5'd5, 5'd1, 5'd2, 1'b0, pw, fl);
    step(OP_R, 5'd6, 5'd5, 5'd1, 1'b0, pw, fl);
    check_value("ldu_pc_write", pw, 0);
    check_value("ldu_bubble_rd", bus.RD_EX, 0);
    check_value("ldu_bubble_regwrite", bus.RegWrite_EX, 0);
    step(OP_R, 5'd6, 5'd5, 5'd1, 1'b0, pw, fl);
    check_value("ldu_release_pc_write", pw, 1);
    check_value("ldu_add_rd", bus.RD_EX, 6);

    // lw x0 never stalls; addi does not read its rs2 field
    step(OP_LOAD, 5'd0, 5'd1, 5'd2, 1'b0, pw, fl);
    step(OP_LOAD, 5'd7, 5'd0, 5'd0, 1'b0, pw, fl);
    check_value("x0_no_stall", pw, 1);
    step(OP_LOAD, 5'd5, 5'd1, 5'd2, 1'b0, pw, fl);
    step(OP_I, 5'd6, 5'd1, 5'd5, 1'b0, pw, fl);
    check_value("addi_rs2_no_stall", pw, 1);

    // Load-use hazard coincident with a taken branch
    step(OP_LOAD, 5'd5, 5'd1, 5'd2, 1'b0, pw, fl);
    step(OP_R, 5'd6, 5'd5, 5'd1, 1'b1, pw, fl);
    check_value("flush_pc_write", pw, 1);
    check_value("flush_if_id_flush", fl, 1);
    check_value("flush_bubble_regwrite", bus.RegWrite_EX, 0);

    // Reset in the middle of a stall
    step(OP_LOAD, 5'd5, 5'd1, 5'd2, 1'b0, pw, fl);
    @(negedge clk);
    bus.OPCODE_ID = OP_R; bus.RD_ID = 5'd6; bus.RS1_ID = 5'd5; bus.RS2_ID = 5'd1; bus.PCSrc = 1'b0;
    #1;
    check_value("pre_rst_stall", bus.PC_write, 0);
    #1;
    reset = 1'b0;
    #1;
    clear_model();
    check_ex();
    check_value("mid_rst_pc_write", bus.PC_write, 1);
    check_value("mid_rst_if_id_write", bus.IF_ID_write, 1);
    @(negedge clk);
    reset = 1'b1;

    // Random instruction stream with a small register pool to provoke hazards
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 5) op = 7'($urandom_range(0, 127));
      else          op = ops[sel];
      step(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), pw, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
